rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Shares the single write port of the 32×32 register file (address, data, write-enable) among NREQ independent writeback sources: pipeline WB, multicycle mul/div result, and late load return. Each source has a valid/ready handshake. Grants rotate round-robin, one write per cycle, through a registered output stage. The block also publishes a pending-write mask that the hazard unit uses to stall readers of registers with writes still in flight.

## Interface
- NREQ, 3: number of requesters, 2..8.
- AW, 5: register address width.
- DW, 32: data width.
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  requester i has a write to offer.
- req_addr  in  NREQ×AW  destination register of requester i.
- req_data  in  NREQ×DW  write data of requester i.
- req_ready  out  NREQ  one-hot grant; the handshake completes when valid and ready are both high.
- rf_we  out  1  write enable to the register file.
- rf_addr  out  AW  register file write address.
- rf_wdata  out  DW  register file write data.
- pending_mask  out  2^AW  bit r set while a write to register r is offered or staged.
- wr_count  out  32  number of committed nonzero-address writes; wraps at 2^32.

## Operation
- **Arbitration:** round-robin over asserted req_valid, starting at pointer ptr.
  - Winner w gets req_ready[w]=1 in the same cycle (combinational).
  - At most one ready bit is high. All ready bits are 0 when no valid is asserted.
- **Pointer update:** on a handshake, ptr <= (w+1) mod NREQ. Otherwise ptr holds.
- **Output stage:** on a handshake, the stage loads {addr, data}. rf_we <= 1 unless addr==0, because $zero is never written; the handshake still completes. With no handshake, rf_we <= 0 and rf_addr/rf_wdata hold their last values.
- **No back-pressure:** the register file accepts a write every cycle, so the output stage never stalls.
- **pending_mask[r]:** the OR of the following terms, with r=0 always excluded:
  - any req_valid[i] with req_addr[i]==r;
  - rf_we && rf_addr==r.
- **wr_count:** increments by 1 in each cycle that rf_we is 1.
- **Same-address requests:** several requesters targeting the same register are serialized in round-robin order. The last granted requester's data is what remains in the register file.
- **Requester contract:** a requester must hold addr/data stable while valid is high and ready is low. The block does not check this.

## Timing
- Reset values: ptr=0, rf_we=0, rf_addr=0, rf_wdata=0, wr_count=0, req_ready=0 while rst is low, pending_mask=0 with no valid requests.
- Latency:
  - Handshake in cycle T gives rf_we=1 during cycle T+1.
  - The register file captures the write at the end of T+1.
  - A read of that register returns the new value from cycle T+2.
- Pending coverage: the pending bit covers cycles T and T+1. It clears in T+2 if there is no new request to that register.
- Throughput: one write per cycle, sustained.
- Starvation bound: a continuously valid requester waits at most NREQ-1 cycles for its grant.
- Reset mid-operation: an asserted rst clears the staged write immediately. A write staged but not yet captured is lost. Requesters must re-offer it after reset.
- Release from reset: the first grant is the lowest-index valid requester, since ptr starts at 0.

## Structure
- Package rf_arb_pkg holds:
  - constants AW=5, DW=32, ZERO_REG=5'd0, NREQ_DEFAULT=3;
  - typedef wr_req_t {addr, data}.
- Sub-module rr_arbiter:
  - parameter N; inputs clk, rst, req[N], advance; outputs grant[N] (one-hot) and gidx.
  - Contains the pointer and the rotating priority logic.
- Top-level rf_write_arbiter contains the output stage, the pending mask and the counter.

## Test plan
- **Reset:** assert rst mid-stream with a staged write to r5 → next cycle rf_we=0 and wr_count=0; r5 is not written; after release, first grant is req 0.
- **Single write:** req1 valid, addr=9, data=0xDEADBEEF.
  - Cycle T: ready[1]=1 and pending_mask[9]=1.
  - Cycle T+1: rf_we=1, rf_addr=9, rf_wdata=0xDEADBEEF.
  - Cycle T+2: wr_count=1 and pending_mask[9]=0.
- **Round-robin:** all three requesters valid every cycle for 6 cycles, starting with ptr=0 → grant order 0,1,2,0,1,2 and rf_we=1 every cycle from T+1.
- **$zero write:** req0 valid, addr=0, data=0x1234 → ready[0]=1, rf_we stays 0, pending_mask[0]=0, wr_count unchanged.
- **Same-address conflict:** req0 (r3, 0x11) and req2 (r3, 0x22) valid together, ptr=0.
  - Writes occur in order 0x11 then 0x22.
  - pending_mask[3] stays 1 until the 0x22 write has been staged.
- **Wrap:** wr_count forced to 0xFFFFFFFF, then one write → wr_count=0.

Source files
------------

// File: rtl/rf_write_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rf_arb_pkg
// Shared constants and types for the register-file write arbiter.
//   AW           : register address width (32 registers)
//   DW           : register data width
//   ZERO_REG     : address of the hard-wired zero register, never written
//   NREQ_DEFAULT : default number of writeback sources
//   wr_req_t     : one write request {addr, data}
// -----------------------------------------------------------------------------
package rf_arb_pkg;

    localparam int AW           = 5;
    localparam int DW           = 32;
    localparam int NREQ_DEFAULT = 3;

    localparam logic [AW-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/rf_write_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with a registered rotating priority pointer.
// The search starts at the pointer and the first asserted request wins; the
// pointer moves to just past the winner only when the caller reports that the
// grant was consumed (advance).
// Ports:
//   clk     in   clock, rising edge
//   rst     in   asynchronous active-low reset (pointer returns to 0)
//   req     in   N request lines
//   advance in   grant consumed this cycle, rotate pointer
//   grant   out  N one-hot grant (all zero when no request)
//   gidx    out  binary index of the winner (0 when no request)
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N  = 3,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] gidx
);

    logic [PW-1:0] r_ptr;
    logic          w_found;

    // Walk the requesters starting at the pointer, wrapping modulo N.
    always_comb begin
        int idx;
        grant   = '0;
        gidx    = '0;
        w_found = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!w_found && req[idx]) begin
                w_found    = 1'b1;
                grant[idx] = 1'b1;
                gidx       = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= (int'(gidx) == N - 1) ? '0 : gidx + PW'(1);
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// rf_write_arbiter
// Shares the single register-file write port among NREQ writeback sources.
// One round-robin grant per cycle; the winner's {addr, data} is staged in a
// registered output stage that drives the register file the next cycle.
// Also publishes a pending-write mask for the hazard unit and a count of
// committed (nonzero-address) writes.
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-low reset
//   req_valid    in   [NREQ]      requester i offers a write
//   req_addr     in   [NREQ*AW]   destination register, requester i at slice i
//   req_data     in   [NREQ*DW]   write data, requester i at slice i
//   req_ready    out  [NREQ]      one-hot grant, combinational
//   rf_we        out              register-file write enable
//   rf_addr      out  [AW]        register-file write address
//   rf_wdata     out  [DW]        register-file write data
//   pending_mask out  [2^AW]      registers with a write offered or staged
//   wr_count     out  [32]        committed write counter, wraps
// -----------------------------------------------------------------------------
module rf_write_arbiter
    import rf_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rf_we,
    output logic [AW-1:0]        rf_addr,
    output logic [DW-1:0]        rf_wdata,
    output logic [(1<<AW)-1:0]   pending_mask,
    output logic [31:0]          wr_count
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    wr_req_t            w_reqs [NREQ];
    wr_req_t            w_sel;
    logic [NREQ-1:0]    w_grant;
    logic [PW-1:0]      w_gidx;
    logic               w_hs;
    logic [(1<<AW)-1:0] w_pend;

    logic               r_we;
    logic [AW-1:0]      r_addr;
    logic [DW-1:0]      r_wdata;
    logic [31:0]        r_wr_count;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_reqs[gi] = {req_addr[gi*AW +: AW], req_data[gi*DW +: DW]};
        end
    endgenerate

    rr_arbiter #(
        .N  (NREQ),
        .PW (PW)
    ) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (w_hs),
        .grant   (w_grant),
        .gidx    (w_gidx)
    );

    // No grant may be visible while reset is held, even though the arbiter
    // would otherwise pick a winner from live valids.
    assign req_ready = rst ? w_grant : '0;

    // The grant only ever selects a valid requester, so any ready bit is a
    // completed handshake.
    assign w_hs  = |req_ready;
    assign w_sel = w_reqs[w_gidx];

    // Output stage never stalls: the register file takes a write every cycle.
    // A $zero write still consumes its grant but is never enabled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wr_count <= '0;
        end else begin
            r_we <= w_hs && (w_sel.addr != ZERO_REG);
            if (w_hs) begin
                r_addr  <= w_sel.addr;
                r_wdata <= w_sel.data;
            end
            if (r_we) begin
                r_wr_count <= r_wr_count + 32'd1;
            end
        end
    end

    // Pending covers both offered requests and the staged write; register 0
    // is forced clear because it can never hold a hazard.
    always_comb begin
        w_pend = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i]) begin
                w_pend[w_reqs[i].addr] = 1'b1;
            end
        end
        if (r_we) begin
            w_pend[r_addr] = 1'b1;
        end
        w_pend[ZERO_REG] = 1'b0;
    end

    assign rf_we        = r_we;
    assign rf_addr      = r_addr;
    assign rf_wdata     = r_wdata;
    assign pending_mask = w_pend;
    assign wr_count     = r_wr_count;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_write_arbiter
// Directed bench for rf_write_arbiter (NREQ=3). Inputs change on the falling
// edge; outputs are sampled 1 time unit later, away from the rising edge.
// -----------------------------------------------------------------------------
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  req_valid = '0;
    logic [14:0] req_addr  = '0;
    logic [95:0] req_data  = '0;
    logic [2:0]  req_ready;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_wdata;
    logic [31:0] pending_mask;
    logic [31:0] wr_count;

    int n_total = 0;
    int n_pass  = 0;

    int         exp_idx [6] = '{0, 1, 2, 0, 1, 2};
    logic [2:0] exp_rdy;

    rf_write_arbiter #(.NREQ(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .rf_we        (rf_we),
        .rf_addr      (rf_addr),
        .rf_wdata     (rf_wdata),
        .pending_mask (pending_mask),
        .wr_count     (wr_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic drive(input int i, input logic [4:0] a, input logic [31:0] d);
        req_addr[i*5 +: 5]  = a;
        req_data[i*32 +: 32] = d;
    endtask

    initial begin
        // ---------------- reset state ----------------
        #1;
        chk("rst_we",    rf_we,        1'b0);
        chk("rst_addr",  rf_addr,      5'd0);
        chk("rst_wdata", rf_wdata,     32'd0);
        chk("rst_count", wr_count,     32'd0);
        chk("rst_pend",  pending_mask, 32'd0);
        chk("rst_ready", req_ready,    3'b000);
        drive(0, 5'd1, 32'hA0);
        drive(1, 5'd2, 32'hA1);
        drive(2, 5'd3, 32'hA2);
        req_valid = 3'b111;
        #1;
        chk("rst_ready_valid", req_ready, 3'b000);
        req_valid = 3'b000;

        @(negedge clk);
        rst = 1'b1;

        // ---------------- round-robin: all valid for 6 cycles ----------------
        req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            #1;
            exp_rdy = 3'b001 << exp_idx[c];
            $display("rr cycle %0d: ready=%b we=%0d addr=%0d", c, req_ready, rf_we, rf_addr);
            chk("rr_ready", req_ready, exp_rdy);
            chk("rr_we", rf_we, c > 0);
            if (c > 0) begin
                chk("rr_addr", rf_addr, exp_idx[c-1] + 1);
            end
            @(negedge clk);
        end
        req_valid = 3'b000;
        #1;
        chk("rr_last_we",    rf_we,    1'b1);
        chk("rr_last_addr",  rf_addr,  5'd3);
        chk("rr_last_data",  rf_wdata, 32'hA2);
        chk("rr_count5",     wr_count, 32'd5);
        @(negedge clk);
        #1;
        chk("rr_idle_we",  rf_we,        1'b0);
        chk("rr_count6",   wr_count,     32'd6);
        chk("rr_idle_pend", pending_mask, 32'd0);

        // ---------------- same-address conflict (ptr=0) ----------------
        @(negedge clk);
        drive(0, 5'd3, 32'h11);
        drive(1, 5'd8, 32'h99);
        drive(2, 5'd3, 32'h22);
        req_valid = 3'b101;
        #1;
        $display("conflict T: ready=%b pend=%h", req_ready, pending_mask);
        chk("cf_ready0", req_ready,    3'b001);
        chk("cf_pend_t", pending_mask, 32'h0000_0008);
        @(negedge clk);
        req_valid = 3'b100;
        #1;
        $display("conflict T+1: ready=%b we=%0d wdata=%h", req_ready, rf_we, rf_wdata);
        chk("cf_ready2",  req_ready,    3'b100);
        chk("cf_we1",     rf_we,        1'b1);
        chk("cf_data1",   rf_wdata,     32'h11);
        chk("cf_pend_t1", pending_mask, 32'h0000_0008);
        @(negedge clk);
        req_valid = 3'b000;
        #1;
        $display("conflict T+2: we=%0d addr=%0d wdata=%h", rf_we, rf_addr, rf_wdata);
        chk("cf_we2",     rf_we,        1'b1);
        chk("cf_addr2",   rf_addr,      5'd3);
        chk("cf_data2",   rf_wdata,     32'h22);
        chk("cf_pend_t2", pending_mask, 32'h0000_0008);
        @(negedge clk);
        #1;
        chk("cf_pend_clr", pending_mask, 32'd0);
        chk("cf_count",    wr_count,     32'd8);

        // ---------------- $zero write (ptr=0) ----------------
        @(negedge clk);
        drive(0, 5'd0, 32'h1234);
        req_valid = 3'b001;
        #1;
        $display("zero T: ready=%b pend=%h", req_ready, pending_mask);
        chk("z_ready", req_ready,    3'b001);
        chk("z_pend",  pending_mask, 32'd0);
        @(negedge clk);
        req_valid = 3'b000;
        #1;
        chk("z_we",    rf_we,        1'b0);
        chk("z_data",  rf_wdata,     32'h1234);
        chk("z_pend1", pending_mask, 32'd0);
        @(negedge clk);
        #1;
        chk("z_count", wr_count, 32'd8);

        // ---------------- single write (ptr=1) ----------------
        @(negedge clk);
        drive(1, 5'd9, 32'hDEAD_BEEF);
        req_valid = 3'b010;
        #1;
        $display("single T: ready=%b pend=%h", req_ready, pending_mask);
        chk("s_ready", req_ready,    3'b010);
        chk("s_pend",  pending_mask, 32'h0000_0200);
        @(negedge clk);
        req_valid = 3'b000;
        #1;
        $display("single T+1: we=%0d addr=%0d wdata=%h", rf_we, rf_addr, rf_wdata);
        chk("s_we",    rf_we,        1'b1);
        chk("s_addr",  rf_addr,      5'd9);
        chk("s_data",  rf_wdata,     32'hDEAD_BEEF);
        chk("s_pend1", pending_mask, 32'h0000_0200);
        @(negedge clk);
        #1;
        chk("s_count", wr_count,     32'd9);
        chk("s_pend2", pending_mask, 32'd0);
        chk("s_we2",   rf_we,        1'b0);

        // ---------------- wr_count wrap (ptr=2) ----------------
        force dut.r_wr_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_wr_count;
        #1;
        chk("w_pre", wr_count, 32'hFFFF_FFFF);
        @(negedge clk);
        drive(2, 5'd7, 32'hA5);
        req_valid = 3'b100;
        #1;
        chk("w_ready", req_ready, 3'b100);
        @(negedge clk);
        req_valid = 3'b000;
        #1;
        chk("w_we", rf_we, 1'b1);
        @(negedge clk);
        #1;
        $display("wrap: wr_count=%h", wr_count);
        chk("w_count", wr_count, 32'd0);

        // ---------------- reset mid-operation (ptr=0) ----------------
        @(negedge clk);
        drive(1, 5'd5, 32'h55);
        req_valid = 3'b010;
        #1;
        chk("r_ready", req_ready,    3'b010);
        chk("r_pend",  pending_mask, 32'h0000_0020);
        @(negedge clk);
        req_valid = 3'b000;
        #1;
        chk("r_staged", rf_we,   1'b1);
        chk("r_addr",   rf_addr, 5'd5);
        rst = 1'b0;
        #1;
        $display("reset asserted: we=%0d count=%h", rf_we, wr_count);
        chk("r_we_clr",  rf_we,    1'b0);
        chk("r_cnt_clr", wr_count, 32'd0);
        chk("r_addr_clr", rf_addr, 5'd0);
        drive(0, 5'd4, 32'h44);
        drive(2, 5'd6, 32'h66);
        req_valid = 3'b111;
        @(posedge clk);
        #1;
        chk("r_we_hold",  rf_we,     1'b0);
        chk("r_cnt_hold", wr_count,  32'd0);
        chk("r_rdy_hold", req_ready, 3'b000);
        @(negedge clk);
        rst = 1'b1;
        #1;
        $display("reset released: ready=%b", req_ready);
        chk("r_first", req_ready, 3'b001);
        @(negedge clk);
        req_valid = 3'b000;
        #1;
        chk("r_first_we",   rf_we,    1'b1);
        chk("r_first_addr", rf_addr,  5'd4);
        chk("r_first_data", rf_wdata, 32'h44);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
